majority_vote_ctrl: RTL

Sequential controller that runs voting sessions for the three-input majority function (result is 1 when at least two of x2, x1, x0 are 1). It opens a session on request, collects one ballot from each of three independent requesters through per-voter valid/ack handshakes, and evaluates the majority once all ballots are in or a timeout expires. It also maintains saturating session statistics. It sits between three ballot sources and the majority datapath, and owns all sequencing of that datapath.

---
 rtl/majority_vote_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/majority_vote_ctrl.sv
// Three-voter majority session controller; VOTE_TIMEOUT_EN compiles in the COLLECT timeout and abstain reporting.
// Latency: ack one cycle after a ballot edge, result_valid two edges after the final ballot; no backpressure, voters hold vote_valid until acked.
module majority_vote_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       vote_valid,
   input  logic [2:0]       vote_bit,
   output logic [2:0]       vote_ack,
   output logic             busy,
   output logic             result_valid,
   output logic             result,
   output logic [2:0]       ballots,
   output logic [2:0]       abstain,
   output logic [CNT_W-1:0] session_count,
   output logic [CNT_W-1:0] yes_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EVAL    = 2'd2
   } state_t;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..255");
   end

   state_t           state_q, state_d;
   logic [2:0]       received_q, received_d;
   logic [2:0]       bal_q, bal_d;
   logic [2:0]       vote_ack_q, vote_ack_d;
   logic             result_valid_q, result_valid_d;
   logic             result_q, result_d;
   logic [2:0]       ballots_q, ballots_d;
   logic [2:0]       abstain_q, abstain_d;
   logic [CNT_W-1:0] session_q, session_d;
   logic [CNT_W-1:0] yes_q, yes_d;
   logic [2:0]       new_votes;
   logic             maj;

`ifdef VOTE_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_q, tmo_d;
`endif

   assign new_votes = vote_valid & ~received_q;
   assign maj       = (bal_q[2] & bal_q[1]) | (bal_q[2] & bal_q[0]) | (bal_q[1] & bal_q[0]);

   always_comb begin
      state_d        = state_q;
      received_d     = received_q;
      bal_d          = bal_q;
      vote_ack_d     = 3'b000;
      result_valid_d = 1'b0;
      result_d       = result_q;
      ballots_d      = ballots_q;
      abstain_d      = abstain_q;
      session_d      = session_q;
      yes_d          = yes_q;
`ifdef VOTE_TIMEOUT_EN
      tmo_d          = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            // The result_valid cycle is still the tail of the previous session.
            if (start && !result_valid_q) begin
               state_d    = COLLECT;
               received_d = 3'b000;
               bal_d      = 3'b000;
`ifdef VOTE_TIMEOUT_EN
               tmo_d      = 8'd0;
`endif
            end
         end
         COLLECT: begin
            vote_ack_d = new_votes;
            received_d = received_q | new_votes;
            bal_d      = (bal_q & ~new_votes) | (vote_bit & new_votes);
            if (received_d == 3'b111) begin
               state_d = EVAL;
            end
`ifdef VOTE_TIMEOUT_EN
            tmo_d = tmo_q + 8'd1;
            if (tmo_q == TMO_LAST) begin
               state_d = EVAL;
            end
`endif
         end
         EVAL: begin
            state_d        = IDLE;
            result_valid_d = 1'b1;
            result_d       = maj;
            ballots_d      = bal_q;
`ifdef VOTE_TIMEOUT_EN
            abstain_d      = ~received_q;
`else
            abstain_d      = 3'b000;
`endif
            if (session_q != {CNT_W{1'b1}}) begin
               session_d = session_q + CNT_W'(1);
            end
            if (maj && (yes_q != {CNT_W{1'b1}})) begin
               yes_d = yes_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         received_q     <= 3'b000;
         bal_q          <= 3'b000;
         vote_ack_q     <= 3'b000;
         result_valid_q <= 1'b0;
         result_q       <= 1'b0;
         ballots_q      <= 3'b000;
         abstain_q      <= 3'b000;
         session_q      <= '0;
         yes_q          <= '0;
`ifdef VOTE_TIMEOUT_EN
         tmo_q          <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         received_q     <= received_d;
         bal_q          <= bal_d;
         vote_ack_q     <= vote_ack_d;
         result_valid_q <= result_valid_d;
         result_q       <= result_d;
         ballots_q      <= ballots_d;
         abstain_q      <= abstain_d;
         session_q      <= session_d;
         yes_q          <= yes_d;
`ifdef VOTE_TIMEOUT_EN
         tmo_q          <= tmo_d;
`endif
      end
   end

   assign vote_ack      = vote_ack_q;
   assign busy          = (state_q == COLLECT) || (state_q == EVAL);
   assign result_valid  = result_valid_q;
   assign result        = result_q;
   assign ballots       = ballots_q;
   assign abstain       = abstain_q;
   assign session_count = session_q;
   assign yes_count     = yes_q;

endmodule
